// File: rtl/wb_coeff_slave.sv
// Wishbone classic slave fronting a byte-writable 32-bit coefficient RAM.
// Fixed-latency IDLE/WAIT/TERM handshake with range checking and abort.
module wb_coeff_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_SIZE   = 5,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        p_wb_CYC_I,
  input  logic        p_wb_STB_I,
  input  logic        p_wb_WE_I,
  input  logic        p_wb_LOCK_I,
  input  logic [3:0]  p_wb_SEL_I,
  input  logic [31:0] p_wb_ADR_I,
  input  logic [31:0] p_wb_DAT_I,
  output logic [31:0] p_wb_DAT_O,
  output logic        p_wb_ACK_O,
  output logic        p_wb_ERR_O,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_TERM
  } state_t;

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic [ADDR_SIZE-1:0] idx_q;
  logic                 we_q;
  logic                 rng_q;
  logic [3:0]           sel_q;
  logic [31:0]          wdat_q;
  logic [31:0]          rdat_q;
  logic                 ack_q;
  logic                 err_q;
  logic [31:0]          mem_q [DEPTH];

  logic [32:0] off;
  logic        in_rng;
  logic        do_acc;
  logic        unused_ok;

  // 33-bit offset: bit 32 is the borrow, so addresses below BASE never wrap
  assign off    = {1'b0, p_wb_ADR_I} - {1'b0, BASE_ADDR};
  assign in_rng = !off[32] && ({2'b00, off[32:2]} < 33'(DEPTH));
  assign do_acc = (state_q == S_WAIT) && p_wb_CYC_I && (cnt_q == 4'd0);

  assign unused_ok = ^{p_wb_LOCK_I, off[1:0]};

  always_ff @(posedge clk) begin
    if (!nRST && do_acc && rng_q && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem_q[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= 32'd0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= 32'd0;
      unique case (state_q)
        S_IDLE: begin
          if (p_wb_CYC_I && p_wb_STB_I) begin
            idx_q   <= off[ADDR_SIZE+1:2];
            we_q    <= p_wb_WE_I;
            sel_q   <= p_wb_SEL_I;
            wdat_q  <= p_wb_DAT_I;
            rng_q   <= in_rng;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!p_wb_CYC_I) begin
            state_q <= S_IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_TERM;
            ack_q   <= rng_q;
            err_q   <= !rng_q;
            if (rng_q && !we_q) rdat_q <= mem_q[idx_q];
          end
        end
        S_TERM: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign p_wb_ACK_O = ack_q;
  assign p_wb_ERR_O = err_q;
  assign p_wb_DAT_O = rdat_q;
  assign busy       = (state_q != S_IDLE);

endmodule
